// File: rtl/mod_inv.sv
// mod_inv: iterative modular inverter over the curve field prime.
// Binary extended Euclid, one reduction step per clock.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   start  - one-cycle request, sampled only in IDLE
//   a      - operand, sampled on the start cycle
//   busy   - high while iterating (RUN)
//   done   - one-cycle pulse when result/err are valid
//   result - a^-1 mod p, held until the next accepted start
//   err    - invalid operand (or timeout), valid with done
//
// Optional macro: MOD_INV_TIMEOUT_EN adds a RUN step counter that aborts
// with err=1 once MAX_CYCLES steps have elapsed without convergence.

package elliptic_curve_structs;
    localparam int P_WIDTH = 7;

    typedef struct packed {
        logic [P_WIDTH-1:0] p;
    } curve_params_t;

    localparam curve_params_t params = '{p: 7'd97};
endpackage

module mod_inv #(
    parameter int P_WIDTH    = elliptic_curve_structs::P_WIDTH,
    parameter int MAX_CYCLES = 4 * P_WIDTH + 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [P_WIDTH-1:0] a,
    output logic               busy,
    output logic               done,
    output logic [P_WIDTH-1:0] result,
    output logic               err
);

    localparam logic [P_WIDTH-1:0] P   =
        P_WIDTH'(elliptic_curve_structs::params.p);
    localparam logic [P_WIDTH-1:0] ONE = P_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [P_WIDTH-1:0] u;
    logic [P_WIDTH-1:0] v;
    logic [P_WIDTH-1:0] x1;
    logic [P_WIDTH-1:0] x2;
    logic [P_WIDTH-1:0] u_nx;
    logic [P_WIDTH-1:0] v_nx;
    logic [P_WIDTH-1:0] x1_nx;
    logic [P_WIDTH-1:0] x2_nx;
    logic [P_WIDTH-1:0] result_nx;
    logic               err_nx;

`ifdef MOD_INV_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
`else
    // Without the timeout the step bound has no hardware meaning.
    if (MAX_CYCLES < 1) begin : g_max_cycles_unused
    end
`endif

    // x/2 mod p: an odd x is made even by adding p in one extra bit.
    function automatic logic [P_WIDTH-1:0] half_mod(
        input logic [P_WIDTH-1:0] x
    );
        logic [P_WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return s[P_WIDTH:1];
    endfunction

    // (x - y) mod p, with the borrow bit selecting the +p correction.
    function automatic logic [P_WIDTH-1:0] sub_mod(
        input logic [P_WIDTH-1:0] x,
        input logic [P_WIDTH-1:0] y
    );
        logic [P_WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[P_WIDTH]) begin
            d = d + {1'b0, P};
        end
        return d[P_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            u      <= '0;
            v      <= '0;
            x1     <= '0;
            x2     <= '0;
            result <= '0;
            err    <= 1'b0;
`ifdef MOD_INV_TIMEOUT_EN
            cnt    <= '0;
`endif
        end else begin
            state  <= state_nx;
            u      <= u_nx;
            v      <= v_nx;
            x1     <= x1_nx;
            x2     <= x2_nx;
            result <= result_nx;
            err    <= err_nx;
`ifdef MOD_INV_TIMEOUT_EN
            cnt    <= cnt_nx;
`endif
        end
    end

    always_comb begin
        state_nx  = state;
        u_nx      = u;
        v_nx      = v;
        x1_nx     = x1;
        x2_nx     = x2;
        result_nx = result;
        err_nx    = err;
`ifdef MOD_INV_TIMEOUT_EN
        cnt_nx    = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (a == '0 || a >= P) begin
                        result_nx = '0;
                        err_nx    = 1'b1;
                        state_nx  = FINISH;
                    end else begin
                        u_nx     = a;
                        v_nx     = P;
                        x1_nx    = ONE;
                        x2_nx    = '0;
`ifdef MOD_INV_TIMEOUT_EN
                        cnt_nx   = '0;
`endif
                        state_nx = RUN;
                    end
                end
            end
            RUN: begin
`ifdef MOD_INV_TIMEOUT_EN
                cnt_nx = cnt + 1'b1;
`endif
                if (u == ONE) begin
                    result_nx = x1;
                    err_nx    = 1'b0;
                    state_nx  = FINISH;
                end else if (v == ONE) begin
                    result_nx = x2;
                    err_nx    = 1'b0;
                    state_nx  = FINISH;
`ifdef MOD_INV_TIMEOUT_EN
                end else if (cnt >= CNT_LAST) begin
                    result_nx = '0;
                    err_nx    = 1'b1;
                    state_nx  = FINISH;
`endif
                end else if (!u[0]) begin
                    u_nx  = u >> 1;
                    x1_nx = half_mod(x1);
                end else if (!v[0]) begin
                    v_nx  = v >> 1;
                    x2_nx = half_mod(x2);
                end else if (u >= v) begin
                    u_nx  = u - v;
                    x1_nx = sub_mod(x1, x2);
                end else begin
                    v_nx  = v - u;
                    x2_nx = sub_mod(x2, x1);
                end
            end
            FINISH: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == FINISH);
    end

endmodule

// File: doc/mod_inv.md
Name: mod_inv

Overview:
- Iterative modular inverter: given a in [1, p-1], computes a^-1 mod p over the curve field prime params.p (elliptic_curve_structs).
- Algorithm: binary extended Euclid, one reduction step per clock.
- Inverse-direction companion to the combinational modular add/sub: converts projective results to affine coordinates and supplies field division for the point-arithmetic datapath.
- start/done handshake toward the point-arithmetic controller.

Parameters:
- P_WIDTH, default P_WIDTH from elliptic_curve_structs, operand/result width in bits.
- MAX_CYCLES, default 4*P_WIDTH+4, step bound used only by the optional timeout.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- start  input  1  single-cycle request; sampled only in IDLE.
- a  input  P_WIDTH  operand; sampled on the start cycle.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when result/err are valid.
- result  output  P_WIDTH  a^-1 mod p; held until the next accepted start.
- err  output  1  invalid operand (or timeout); valid with done, held with result.

Behaviour:
- Reset values: busy=0, done=0, result=0, err=0, FSM=IDLE, internal u/v/x1/x2/counter=0.
- Reset asserted mid-operation: the computation is abandoned, no done pulse is issued, and the FSM returns to IDLE.
- FSM states: IDLE, RUN, FINISH.
- IDLE, start=1, and a==0 or a>=p: go to FINISH with err=1 and result=0. No RUN cycles.
- IDLE, start=1, valid a: load u=a, v=p, x1=1, x2=0, counter=0, then go to RUN.
- IDLE, start=0: stay in IDLE.
- start while busy or in FINISH: ignored and not queued.
- RUN: exactly one action per cycle, checked in this priority order:
  1. u==1: result=x1, go to FINISH.
  2. v==1: result=x2, go to FINISH.
  3. u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+p)>>1.
  4. v even: v=v>>1; x2 handled the same way as x1.
  5. u>=v: u=u-v; x1=(x1-x2) mod p.
  6. otherwise: v=v-u; x2=(x2-x1) mod p.
- Width rules:
  - (x+p) is formed in P_WIDTH+1 bits before the shift; the shifted value is always < p.
  - Modular subtract: compute a P_WIDTH+1-bit difference; if the borrow (MSB) is set, add p. Result is always in [0, p-1].
  - u and v are P_WIDTH bits, never exceed p, and never go negative.
- FINISH: done=1 for exactly one cycle, busy=0, then return to IDLE. start is accepted again in IDLE on the following cycle.
- Latency:
  - start to done is at most 4*P_WIDTH+2 cycles for prime p.
  - a=1 takes exactly 2 cycles: one RUN cycle, then FINISH.
- result and err change only on the cycle done is asserted.

Optional Feature:
- Macro: MOD_INV_TIMEOUT_EN.
- Defined:
  - counter increments on every RUN cycle.
  - If counter reaches MAX_CYCLES without u==1 or v==1, go to FINISH with err=1 and result=0. This guards against a non-prime/misconfigured modulus or gcd(a,p)≠1.
- Undefined:
  - No counter logic is synthesized and err reports only invalid operands.
  - Behaviour with a non-invertible operand is unspecified (RUN may not terminate); the caller guarantees a prime p.

Test Plan:
- All scenarios use a test package with P_WIDTH=7, p=97.
- a=3, start pulse -> done within 30 cycles, result=65, err=0; busy high throughout, done high for exactly 1 cycle.
- a=1 -> result=1 with done on the 2nd cycle after start; a=96 -> result=96; a=2 -> result=49.
- a=0 and a=97, each with a start pulse -> done 1 cycle after start, err=1, result=0, no RUN cycles.
- Sweep a=1..96 against a reference model -> (a*result) mod 97 == 1 for every a; worst-case latency ≤ 30 cycles.
- Mid-operation events: start with a=3, then reset asserted 5 cycles later -> outputs return to 0 asynchronously and no done pulse is seen. A second start while busy is ignored: result is still 65 and exactly one done pulse occurs.
- MOD_INV_TIMEOUT_EN with MAX_CYCLES=3 and a=3 -> done with err=1, result=0 after 3 RUN cycles.
